// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, default select width
// and the multiply/divide sequencer states.
package alu_pkg;

  localparam int OP_SIZE_DEFAULT = 4;

  typedef logic [3:0] op_t;

  localparam op_t OP_ADD   = 4'd0;
  localparam op_t OP_SUB   = 4'd1;
  localparam op_t OP_AND   = 4'd2;
  localparam op_t OP_OR    = 4'd3;
  localparam op_t OP_XOR   = 4'd4;
  localparam op_t OP_NOR   = 4'd5;
  localparam op_t OP_SLT   = 4'd6;
  localparam op_t OP_SLTU  = 4'd7;
  localparam op_t OP_MULT  = 4'd8;
  localparam op_t OP_MULTU = 4'd9;
  localparam op_t OP_DIV   = 4'd10;
  localparam op_t OP_DIVU  = 4'd11;
  localparam op_t OP_MFHI  = 4'd12;
  localparam op_t OP_MFLO  = 4'd13;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Execute-stage bus of the multi-cycle ALU: operands and op in, result,
// flags, HI/LO and the start/busy/done handshake out.
interface alu_seq_if #(
  parameter int WIDTH   = 32,
  parameter int OP_SIZE = alu_pkg::OP_SIZE_DEFAULT
);
  // Handshake: start is taken on a rising edge only while busy is low; done
  // is a one-cycle pulse marking the cycle alu_out and the flags were updated.
  logic               start;
  logic [OP_SIZE-1:0] sel;
  logic [WIDTH-1:0]   data_1;
  logic [WIDTH-1:0]   data_2;
  logic [WIDTH-1:0]   alu_out;
  logic               alu_zero_flag;
  logic               alu_oflow;
  logic               div_by_zero;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               busy;
  logic               done;
  alu_pkg::state_t    state;

  modport master (
    output start, sel, data_1, data_2,
    input  alu_out, alu_zero_flag, alu_oflow, div_by_zero, hi, lo, busy, done, state
  );

  modport slave (
    input  start, sel, data_1, data_2,
    output alu_out, alu_zero_flag, alu_oflow, div_by_zero, hi, lo, busy, done, state
  );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide engine: shift-add multiply or restoring divide on
// operand magnitudes, one bit per cycle, followed by a sign fix-up state.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             fin,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res,
  output state_t           state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               neg_hi;
  logic               neg_lo;
  logic               div_q;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               sign_x;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    mag_a  = (is_signed && a[WIDTH-1]) ? -a : a;
    mag_b  = (is_signed && b[WIDTH-1]) ? -b : b;
    sign_x = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    // Remainder sits in the upper half, dividend/quotient in the lower half.
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
  end

  always_comb begin
    prod_fix = neg_hi ? -acc : acc;
    quo_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (div_q) begin
      hi_res = rem_fix;
      lo_res = quo_fix;
    end else begin
      hi_res = prod_fix[2*WIDTH-1:WIDTH];
      lo_res = prod_fix[WIDTH-1:0];
    end
  end

  assign busy = (state != IDLE);
  assign fin  = (state == FIX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      neg_hi <= 1'b0;
      neg_lo <= 1'b0;
      div_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            cnt   <= '0;
            div_q <= is_div;
            if (is_div) begin
              acc    <= {{WIDTH{1'b0}}, mag_a};
              opnd   <= mag_b;
              neg_lo <= sign_x;
              neg_hi <= is_signed & a[WIDTH-1];
              state  <= DIV;
            end else begin
              acc    <= {{WIDTH{1'b0}}, mag_b};
              opnd   <= mag_a;
              neg_lo <= sign_x;
              neg_hi <= sign_x;
              state  <= MUL;
            end
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        DIV: begin
          if (div_shift >= {1'b0, opnd})
            acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          else
            acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU top: single-cycle datapath, flags, HI/LO registers and the
// start/busy/done handshake around the iterative multiply/divide engine.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int OP_SIZE = alu_pkg::OP_SIZE_DEFAULT
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [OP_SIZE-1:0] sel_w;
  op_t                op_c;
  logic [WIDTH-1:0]   d1;
  logic [WIDTH-1:0]   d2;
  logic               accept;

  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_ovf;
  logic               is_mul_op;
  logic               is_div_op;
  logic               go;
  logic               is_signed;

  logic               md_busy;
  logic               md_fin;
  logic [WIDTH-1:0]   hi_res;
  logic [WIDTH-1:0]   lo_res;
  state_t             md_state;

  logic [WIDTH-1:0]   out_q;
  logic               zero_q;
  logic               ovf_q;
  logic               dbz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;
  logic               pend_div;
  logic               pend_ovf;

  assign sel_w  = bus.sel;
  assign op_c   = op_t'(sel_w);
  assign d1     = bus.data_1;
  assign d2     = bus.data_2;
  assign accept = bus.start & ~md_busy;

  always_comb begin
    sum    = d1 + d2;
    diff   = d1 - d2;
    sc_res = '0;
    sc_ovf = 1'b0;
    case (op_c)
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (d1[WIDTH-1] == d2[WIDTH-1]) && (sum[WIDTH-1] != d1[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (d1[WIDTH-1] != d2[WIDTH-1]) && (diff[WIDTH-1] != d1[WIDTH-1]);
      end
      OP_AND:  sc_res = d1 & d2;
      OP_OR:   sc_res = d1 | d2;
      OP_XOR:  sc_res = d1 ^ d2;
      OP_NOR:  sc_res = ~(d1 | d2);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(d1) < $signed(d2))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (d1 < d2)};
      OP_MFHI: sc_res = hi_q;
      OP_MFLO: sc_res = lo_q;
      default: sc_res = '0;
    endcase
  end

  always_comb begin
    is_mul_op = (op_c == OP_MULT) || (op_c == OP_MULTU);
    is_div_op = (op_c == OP_DIV) || (op_c == OP_DIVU);
    is_signed = (op_c == OP_MULT) || (op_c == OP_DIV);
    // A zero divisor is resolved here in one cycle and never starts the engine.
    go        = accept && (is_mul_op || (is_div_op && (d2 != '0)));
  end

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .is_div    (is_div_op),
    .is_signed (is_signed),
    .a         (d1),
    .b         (d2),
    .busy      (md_busy),
    .fin       (md_fin),
    .hi_res    (hi_res),
    .lo_res    (lo_res),
    .state     (md_state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      pend_div <= 1'b0;
      pend_ovf <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        if (is_mul_op || (is_div_op && (d2 != '0))) begin
          pend_div <= is_div_op;
          pend_ovf <= (op_c == OP_DIV) && (d1 == MIN_VAL) && (d2 == '1);
        end else if (is_div_op) begin
          hi_q   <= d1;
          lo_q   <= '1;
          out_q  <= '1;
          zero_q <= 1'b0;
          ovf_q  <= 1'b0;
          dbz_q  <= 1'b1;
          done_q <= 1'b1;
        end else begin
          out_q  <= sc_res;
          zero_q <= (sc_res == '0);
          ovf_q  <= sc_ovf;
          if (op_c > OP_MFLO) dbz_q <= 1'b0;
          done_q <= 1'b1;
        end
      end else if (md_fin) begin
        hi_q   <= hi_res;
        lo_q   <= lo_res;
        out_q  <= lo_res;
        zero_q <= (lo_res == '0);
        ovf_q  <= pend_ovf;
        if (pend_div) dbz_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign bus.alu_out       = out_q;
  assign bus.alu_zero_flag = zero_q;
  assign bus.alu_oflow     = ovf_q;
  assign bus.div_by_zero   = dbz_q;
  assign bus.hi            = hi_q;
  assign bus.lo            = lo_q;
  assign bus.busy          = md_busy;
  assign bus.done          = done_q;
  assign bus.state         = md_state;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed scenarios plus random ops checked against an
// arithmetic reference model of the ALU's architectural behaviour.
module tb_alu_seq;

  localparam int W = 32;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_dbz = 1'b0;
  logic [W-1:0] corner [5];

  alu_seq_if #(.WIDTH(W), .OP_SIZE(4)) bus ();

  alu_seq #(.WIDTH(W), .OP_SIZE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit interfere);
    longint sa, sb, sr, sm;
    logic [63:0] p;
    logic [W-1:0] e_out;
    logic e_ovf;
    int e_lat, lat;
    string t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e_out = '0;
    e_ovf = 1'b0;
    e_lat = 1;
    case (op)
      4'd0: begin sr = sa + sb; e_out = a + b; e_ovf = (sr > MAXS) || (sr < MINS); end
      4'd1: begin sr = sa - sb; e_out = a - b; e_ovf = (sr > MAXS) || (sr < MINS); end
      4'd2: e_out = a & b;
      4'd3: e_out = a | b;
      4'd4: e_out = a ^ b;
      4'd5: e_out = ~(a | b);
      4'd6: e_out = (sa < sb) ? 32'd1 : 32'd0;
      4'd7: e_out = (a < b) ? 32'd1 : 32'd0;
      4'd8, 4'd9: begin
        if (op == 4'd8) p = sa * sb;
        else p = {32'b0, a} * {32'b0, b};
        m_hi = p[63:32];
        m_lo = p[31:0];
        e_out = m_lo;
        e_lat = W + 2;
      end
      4'd10, 4'd11: begin
        if (b == '0) begin
          m_hi = a;
          m_lo = '1;
          e_out = '1;
          m_dbz = 1'b1;
        end else begin
          if (op == 4'd10) begin
            sr = sa / sb;
            sm = sa % sb;
            e_ovf = (sr > MAXS);
          end else begin
            sr = longint'({32'b0, a}) / longint'({32'b0, b});
            sm = longint'({32'b0, a}) % longint'({32'b0, b});
          end
          m_lo = sr[31:0];
          m_hi = sm[31:0];
          e_out = m_lo;
          m_dbz = 1'b0;
          e_lat = W + 2;
        end
      end
      4'd12: e_out = m_hi;
      4'd13: e_out = m_lo;
      default: begin e_out = '0; m_dbz = 1'b0; end
    endcase

    @(negedge clk);
    bus.start = 1'b1;
    bus.sel = op;
    bus.data_1 = a;
    bus.data_2 = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.sel = 4'($urandom);
    bus.data_1 = $urandom;
    bus.data_2 = $urandom;
    t = $sformatf("op%0d", op);
    if (e_lat > 1) check({t, "_busy_rise"}, bus.busy, 1);
    lat = 1;
    while (!bus.done && lat < 60) begin
      if (interfere && lat == 5) begin
        bus.start = 1'b1;
        bus.sel = 4'd0;
        bus.data_1 = 32'h1;
        bus.data_2 = 32'h2;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
    check({t, "_latency"}, lat, e_lat);
    check({t, "_done"}, bus.done, 1);
    check({t, "_busy_fall"}, bus.busy, 0);
    check({t, "_alu_out"}, bus.alu_out, e_out);
    check({t, "_zero"}, bus.alu_zero_flag, (e_out == '0));
    check({t, "_oflow"}, bus.alu_oflow, e_ovf);
    check({t, "_dbz"}, bus.div_by_zero, m_dbz);
    check({t, "_hi"}, bus.hi, m_hi);
    check({t, "_lo"}, bus.lo, m_lo);
    @(posedge clk);
    #1;
    check({t, "_done_pulse"}, bus.done, 0);
    check({t, "_hold"}, bus.alu_out, e_out);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    corner[0] = 32'h0;
    corner[1] = 32'h1;
    corner[2] = 32'hFFFFFFFF;
    corner[3] = 32'h80000000;
    corner[4] = 32'h7FFFFFFF;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.sel = '0;
    bus.data_1 = '0;
    bus.data_2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_alu_out", bus.alu_out, 0);
    check("rst_flags", {bus.alu_zero_flag, bus.alu_oflow, bus.div_by_zero}, 0);
    check("rst_hilo", {bus.hi, bus.lo}, 0);
    check("rst_busy_done", {bus.busy, bus.done}, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(4'd0, 32'h7FFFFFFF, 32'h00000001, 0);
    check("tp_add_out", bus.alu_out, 32'h80000000);
    check("tp_add_ovf", bus.alu_oflow, 1);
    run_op(4'd6, 32'hFFFFFFFF, 32'h00000001, 0);
    check("tp_slt", bus.alu_out, 32'd1);
    run_op(4'd7, 32'hFFFFFFFF, 32'h00000001, 0);
    check("tp_sltu", bus.alu_out, 32'd0);
    run_op(4'd1, 32'd5, 32'd5, 0);
    check("tp_sub_zero", bus.alu_zero_flag, 1);
    run_op(4'd8, -32'sd3, 32'd7, 0);
    check("tp_mult_hi", bus.hi, 32'hFFFFFFFF);
    check("tp_mult_lo", bus.lo, 32'hFFFFFFEB);
    run_op(4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    check("tp_multu_hi", bus.hi, 32'hFFFFFFFE);
    check("tp_multu_lo", bus.lo, 32'h00000001);
    run_op(4'd12, 32'h0, 32'h0, 0);
    run_op(4'd10, -32'sd7, 32'd2, 0);
    check("tp_div_lo", bus.lo, 32'hFFFFFFFD);
    check("tp_div_hi", bus.hi, 32'hFFFFFFFF);
    run_op(4'd11, 32'd7, 32'd0, 0);
    check("tp_divu0_dbz", bus.div_by_zero, 1);
    check("tp_divu0_hi", bus.hi, 32'd7);
    run_op(4'd13, 32'h0, 32'h0, 0);
    run_op(4'd10, 32'h80000000, 32'hFFFFFFFF, 0);
    check("tp_divmin_lo", bus.lo, 32'h80000000);
    check("tp_divmin_ovf", bus.alu_oflow, 1);
    run_op(4'd8, -32'sd3, 32'd7, 1);
    check("tp_ignored_add_lo", bus.lo, 32'hFFFFFFEB);
    run_op(4'd14, 32'h1234, 32'h5678, 0);

    // Reset during a divide.
    @(negedge clk);
    bus.start = 1'b1;
    bus.sel = 4'd10;
    bus.data_1 = 32'd100;
    bus.data_2 = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_alu_out", bus.alu_out, 0);
    check("midrst_hilo", {bus.hi, bus.lo}, 0);
    check("midrst_flags", {bus.alu_zero_flag, bus.alu_oflow, bus.div_by_zero}, 0);
    check("midrst_busy_done", {bus.busy, bus.done}, 0);
    m_hi = '0;
    m_lo = '0;
    m_dbz = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("postrst_no_done", {bus.busy, bus.done}, 0);
    end
    run_op(4'd0, 32'd10, 32'd20, 0);

    for (int i = 0; i < 30; i++) begin
      logic [3:0] op;
      logic [W-1:0] a, b;
      op = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      run_op(op, a, b, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
